// File: rtl/alarm_set_if.sv
// alarm_set_if: bundles the front-panel inputs and the alarm-time outputs of alarm_set.
//
// Signal summary
//   tick       panel -> alarm_set   1-cycle 1 ms timebase strobe
//   btn_mode   panel -> alarm_set   debounced level, cycles IDLE -> EDIT_H -> EDIT_M -> commit
//   btn_up     panel -> alarm_set   debounced level, increment selected field
//   btn_down   panel -> alarm_set   debounced level, decrement selected field
//   btn_onoff  panel -> alarm_set   debounced level, toggle arm (IDLE only)
//   timerH     alarm_set -> rest    committed hour 0..23
//   timerM     alarm_set -> rest    committed minute 0..59
//   enable     alarm_set -> rest    armed and idle
//   editing    alarm_set -> rest    1 in EDIT_H/EDIT_M
//   sel_h      alarm_set -> rest    1 in EDIT_H
//   blink      alarm_set -> rest    edit-field blink, 0 in IDLE
//   disp_h     alarm_set -> rest    shadow hour while editing, else timerH
//   disp_m     alarm_set -> rest    shadow minute while editing, else timerM
//   dbg_state  alarm_set -> rest    FSM state (0 IDLE, 1 EDIT_H, 2 EDIT_M)
//
// Transfer semantics: there is no valid/ready pair here. Buttons are plain levels
// sampled on every rising clock edge; a press is a 0->1 change between two samples.
// tick is a single-cycle strobe counted on every edge where it is 1. Outputs are
// registered values (or fixed decodes of registers) and are always valid.
interface alarm_set_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_onoff;
  logic [4:0] timerH;
  logic [5:0] timerM;
  logic       enable;
  logic       editing;
  logic       sel_h;
  logic       blink;
  logic [4:0] disp_h;
  logic [5:0] disp_m;
  logic [1:0] dbg_state;

  modport master (
    output tick, btn_mode, btn_up, btn_down, btn_onoff,
    input  timerH, timerM, enable, editing, sel_h, blink, disp_h, disp_m, dbg_state
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, btn_onoff,
    output timerH, timerM, enable, editing, sel_h, blink, disp_h, disp_m, dbg_state
  );
endinterface

// File: rtl/alarm_set.sv
// alarm_set: writer side of the alarm-compare path. Front-panel buttons edit shadow
// copies of the alarm hour/minute; the committed timerH/timerM only change on the
// final mode press, so the comparator never sees a half-set time. Includes
// auto-repeat on held up/down, hour/minute wrap-around, edit timeout and a blink
// output for the display.
//
// Ports
//   mclk  in  system clock, all state on rising edge
//   rst   in  asynchronous active-high reset
//   bus   alarm_set_if.slave: buttons/tick in, alarm time, flags and display out
module alarm_set #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 10000,
  parameter int BLINK_HALF   = 250
) (
  input  logic       mclk,
  input  logic       rst,
  alarm_set_if.slave bus
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam int BLINK_W  = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic               r_prev_mode, r_prev_up, r_prev_down, r_prev_onoff;
  logic [4:0]         r_timer_h, r_shadow_h;
  logic [5:0]         r_timer_m, r_shadow_m;
  logic               r_armed;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_repeating;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;

  logic               w_mode_edge, w_up_edge, w_down_edge, w_onoff_edge;
  logic               w_editing, w_one_held, w_rep_hit;
  logic               w_step_up, w_step_down, w_step, w_tmo_hit;
  logic               w_load, w_commit;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic [BLINK_W-1:0] w_blink_inc;

  assign w_mode_edge  = bus.btn_mode  & ~r_prev_mode;
  assign w_up_edge    = bus.btn_up    & ~r_prev_up;
  assign w_down_edge  = bus.btn_down  & ~r_prev_down;
  assign w_onoff_edge = bus.btn_onoff & ~r_prev_onoff;

  assign w_editing  = (r_state != ST_IDLE);
  assign w_one_held = bus.btn_up ^ bus.btn_down;

  // First repeat step after REPEAT_DELAY held ticks, then one every REPEAT_RATE;
  // the counter restarts from zero at each repeat step.
  assign w_hold_inc = r_hold_cnt + 1'b1;
  assign w_rep_hit  = w_editing & w_one_held & bus.tick &
                      (r_repeating ? (w_hold_inc == HOLD_W'(REPEAT_RATE))
                                   : (w_hold_inc == HOLD_W'(REPEAT_DELAY)));

  // A step needs exactly one of up/down held; a mode press in the same cycle wins.
  assign w_step_up   = w_editing & ~w_mode_edge & bus.btn_up & ~bus.btn_down &
                       (w_up_edge | w_rep_hit);
  assign w_step_down = w_editing & ~w_mode_edge & bus.btn_down & ~bus.btn_up &
                       (w_down_edge | w_rep_hit);
  assign w_step      = w_step_up | w_step_down;

  assign w_tmo_inc = r_tmo_cnt + 1'b1;
  assign w_tmo_hit = w_editing & bus.tick & ~w_step & ~w_mode_edge &
                     (w_tmo_inc == TMO_W'(TIMEOUT));

  assign w_blink_inc = r_blink_cnt + 1'b1;

  // FSM state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state; w_load copies committed time into the shadows, w_commit
  // copies the shadows back out.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mode_edge) begin
          w_state_next = ST_EDIT_H;
          w_load       = 1'b1;
        end
      end
      ST_EDIT_H: begin
        if (w_mode_edge)    w_state_next = ST_EDIT_M;
        else if (w_tmo_hit) w_state_next = ST_IDLE;
      end
      ST_EDIT_M: begin
        if (w_mode_edge) begin
          w_state_next = ST_IDLE;
          w_commit     = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Button history; reset to 1 so a button held through reset is not a press.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_prev_mode  <= 1'b1;
      r_prev_up    <= 1'b1;
      r_prev_down  <= 1'b1;
      r_prev_onoff <= 1'b1;
    end else begin
      r_prev_mode  <= bus.btn_mode;
      r_prev_up    <= bus.btn_up;
      r_prev_down  <= bus.btn_down;
      r_prev_onoff <= bus.btn_onoff;
    end
  end

  // Committed time, shadows and arm flag
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_timer_h  <= 5'd0;
      r_timer_m  <= 6'd0;
      r_shadow_h <= 5'd0;
      r_shadow_m <= 6'd0;
      r_armed    <= 1'b0;
    end else begin
      if (!w_editing && w_onoff_edge) r_armed <= ~r_armed;
      if (w_commit) begin
        r_timer_h <= r_shadow_h;
        r_timer_m <= r_shadow_m;
      end
      if (w_load) begin
        r_shadow_h <= r_timer_h;
        r_shadow_m <= r_timer_m;
      end else if (w_step) begin
        if (r_state == ST_EDIT_H) begin
          if (w_step_up) r_shadow_h <= (r_shadow_h == 5'd23) ? 5'd0  : r_shadow_h + 5'd1;
          else           r_shadow_h <= (r_shadow_h == 5'd0)  ? 5'd23 : r_shadow_h - 5'd1;
        end else begin
          if (w_step_up) r_shadow_m <= (r_shadow_m == 6'd59) ? 6'd0  : r_shadow_m + 6'd1;
          else           r_shadow_m <= (r_shadow_m == 6'd0)  ? 6'd59 : r_shadow_m - 6'd1;
        end
      end
    end
  end

  // Hold, timeout and blink counters; all idle at zero outside the edit states.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_hold_cnt  <= '0;
      r_repeating <= 1'b0;
      r_tmo_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      if (!w_editing || !w_one_held || w_mode_edge) begin
        r_hold_cnt  <= '0;
        r_repeating <= 1'b0;
      end else if (bus.tick) begin
        if (w_rep_hit) begin
          r_hold_cnt  <= '0;
          r_repeating <= 1'b1;
        end else begin
          r_hold_cnt <= w_hold_inc;
        end
      end

      if (!w_editing || w_step || w_mode_edge || w_tmo_hit) r_tmo_cnt <= '0;
      else if (bus.tick)                                    r_tmo_cnt <= w_tmo_inc;

      if (!w_editing) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b0;
      end else if (bus.tick) begin
        if (w_blink_inc == BLINK_W'(BLINK_HALF)) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= w_blink_inc;
        end
      end
    end
  end

  assign bus.timerH    = r_timer_h;
  assign bus.timerM    = r_timer_m;
  assign bus.enable    = r_armed & ~w_editing;
  assign bus.editing   = w_editing;
  assign bus.sel_h     = (r_state == ST_EDIT_H);
  // Gated so the cycle right after an abort/commit already shows 0.
  assign bus.blink     = r_blink & w_editing;
  assign bus.disp_h    = w_editing ? r_shadow_h : r_timer_h;
  assign bus.disp_m    = w_editing ? r_shadow_m : r_timer_m;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_alarm_set.sv
// tb_alarm_set: directed bench for alarm_set with small timing parameters.
// A behavioural model (clock-time arithmetic, tick counts since press / since
// last step / since entering edit) is compared against every output on each
// falling edge; directed literal checks pin the model at key points.
module tb_alarm_set;

  localparam int P_DELAY = 4;
  localparam int P_RATE  = 2;
  localparam int P_TMO   = 8;
  localparam int P_BLINK = 3;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  logic chk_en = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  alarm_set_if bus ();

  alarm_set #(
    .REPEAT_DELAY (P_DELAY),
    .REPEAT_RATE  (P_RATE),
    .TIMEOUT      (P_TMO),
    .BLINK_HALF   (P_BLINK)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // st: 0 idle, 1 editing hour, 2 editing minute
  // held: ticks since the single held step button went down
  // idle: ticks since last step/mode press in edit
  // edit: ticks since entering edit
  typedef struct packed {
    int   st;
    int   th;
    int   tm;
    int   sh;
    int   sm;
    int   held;
    int   idle;
    int   edit;
    logic armed;
    logic pm;
    logic pu;
    logic pd;
    logic po;
  } model_t;

  model_t ms;

  function automatic model_t model_reset();
    model_t n;
    n.st = 0; n.th = 0; n.tm = 0; n.sh = 0; n.sm = 0;
    n.held = 0; n.idle = 0; n.edit = 0;
    n.armed = 1'b0;
    n.pm = 1'b1; n.pu = 1'b1; n.pd = 1'b1; n.po = 1'b1;
    return n;
  endfunction

  function automatic model_t next_model(input model_t s, input logic md, input logic up,
                                        input logic dn, input logic oo, input logic tk);
    model_t n;
    int     dir;
    logic   e_md, e_up, e_dn, e_oo;
    n    = s;
    dir  = 0;
    e_md = md & ~s.pm;
    e_up = up & ~s.pu;
    e_dn = dn & ~s.pd;
    e_oo = oo & ~s.po;
    if (s.st == 0) begin
      if (e_oo) n.armed = ~s.armed;
      if (e_md) begin
        n.st = 1;
        n.sh = s.th;
        n.sm = s.tm;
      end
    end else begin
      if (tk) n.edit = s.edit + 1;
      if (e_md) begin
        n.held = 0;
        n.idle = 0;
        if (s.st == 2) begin
          n.th = s.sh;
          n.tm = s.sm;
          n.st = 0;
        end else begin
          n.st = 2;
        end
      end else begin
        if (up != dn) begin
          if (tk) n.held = s.held + 1;
          if ((up && e_up) || (dn && e_dn)) dir = up ? 1 : -1;
          if (tk && n.held >= P_DELAY && ((n.held - P_DELAY) % P_RATE) == 0) dir = up ? 1 : -1;
        end else begin
          n.held = 0;
        end
        if (dir != 0) begin
          n.idle = 0;
          if (s.st == 1) n.sh = (s.sh + dir + 24) % 24;
          else           n.sm = (s.sm + dir + 60) % 60;
        end else if (tk) begin
          n.idle = s.idle + 1;
          if (n.idle >= P_TMO) n.st = 0;
        end
      end
    end
    if (n.st == 0) begin
      n.held = 0;
      n.idle = 0;
      n.edit = 0;
    end
    n.pm = md; n.pu = up; n.pd = dn; n.po = oo;
    return n;
  endfunction

  always @(posedge mclk or posedge rst) begin
    if (rst) ms <= model_reset();
    else     ms <= next_model(ms, bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_onoff, bus.tick);
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    if (chk_en) begin
      cmp("m_timerH",  8'(bus.timerH),  8'(ms.th));
      cmp("m_timerM",  8'(bus.timerM),  8'(ms.tm));
      cmp("m_enable",  8'(bus.enable),  8'((ms.st == 0) && ms.armed));
      cmp("m_editing", 8'(bus.editing), 8'(ms.st != 0));
      cmp("m_sel_h",   8'(bus.sel_h),   8'(ms.st == 1));
      cmp("m_blink",   8'(bus.blink),   8'((ms.st != 0) ? ((ms.edit / P_BLINK) % 2) : 0));
      cmp("m_disp_h",  8'(bus.disp_h),  8'((ms.st != 0) ? ms.sh : ms.th));
      cmp("m_disp_m",  8'(bus.disp_m),  8'((ms.st != 0) ? ms.sm : ms.tm));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_cyc();
    @(negedge mclk);
    #1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1; step_cyc();
    bus.btn_mode = 1'b0; step_cyc();
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_up = 1'b1; step_cyc();
      bus.btn_up = 1'b0; step_cyc();
    end
  endtask

  task automatic press_down(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_down = 1'b1; step_cyc();
      bus.btn_down = 1'b0; step_cyc();
    end
  endtask

  task automatic press_onoff();
    bus.btn_onoff = 1'b1; step_cyc();
    bus.btn_onoff = 1'b0; step_cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1; step_cyc();
      bus.tick = 1'b0; step_cyc();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.btn_onoff = 1'b0;
    step_cyc();
    step_cyc();
    rst = 1'b0;
    step_cyc();
    chk_en = 1'b1;

    // reset state
    cmp("rst_timerH",  8'(bus.timerH),  8'd0);
    cmp("rst_timerM",  8'(bus.timerM),  8'd0);
    cmp("rst_enable",  8'(bus.enable),  8'd0);
    cmp("rst_editing", 8'(bus.editing), 8'd0);
    cmp("rst_blink",   8'(bus.blink),   8'd0);

    // set 3:59 from 0:00; committed time held until the final mode press
    press_mode();
    press_up(3);
    cmp("t2_disp_h", 8'(bus.disp_h),  8'd3);
    cmp("t2_hold_h", 8'(bus.timerH),  8'd0);
    cmp("t2_sel_h",  8'(bus.sel_h),   8'd1);
    press_mode();
    press_down(1);
    cmp("t2_disp_m", 8'(bus.disp_m),  8'd59);
    cmp("t2_hold_m", 8'(bus.timerM),  8'd0);
    cmp("t2_sel_m",  8'(bus.sel_h),   8'd0);
    press_mode();
    cmp("t2_timerH", 8'(bus.timerH),  8'd3);
    cmp("t2_timerM", 8'(bus.timerM),  8'd59);
    cmp("t2_idle",   8'(bus.editing), 8'd0);

    // arm, edit suppresses enable and ignores onoff, commit restores
    press_onoff();
    cmp("t6_armed",    8'(bus.enable),  8'd1);
    press_mode();
    cmp("t6_edit_en",  8'(bus.enable),  8'd0);
    cmp("t6_shadow_h", 8'(bus.disp_h),  8'd3);
    press_onoff();
    cmp("t6_onoff_ign", 8'(bus.enable), 8'd0);
    press_mode();
    press_mode();
    cmp("t6_commit_en", 8'(bus.enable), 8'd1);
    cmp("t6_timerH",    8'(bus.timerH), 8'd3);

    // wrap-around
    press_mode();
    press_down(4);
    cmp("t3_h_wrap_dn", 8'(bus.disp_h), 8'd23);
    press_up(1);
    cmp("t3_h_wrap_up", 8'(bus.disp_h), 8'd0);
    press_down(1);
    cmp("t3_h_back",    8'(bus.disp_h), 8'd23);
    press_mode();
    cmp("t3_m_load",    8'(bus.disp_m), 8'd59);
    press_up(1);
    cmp("t3_m_wrap_up", 8'(bus.disp_m), 8'd0);
    press_mode();
    cmp("t3_timerH",    8'(bus.timerH), 8'd23);
    cmp("t3_timerM",    8'(bus.timerM), 8'd0);

    // auto-repeat in EDIT_M from 0: press, then ticks 4,6,8,10
    press_mode();
    press_mode();
    bus.btn_up = 1'b1;
    step_cyc();
    cmp("t4_press", 8'(bus.disp_m), 8'd1);
    ticks(10);
    cmp("t4_repeat", 8'(bus.disp_m), 8'd5);
    cmp("t4_blink",  8'(bus.blink),  8'd1);
    bus.btn_down = 1'b1;
    ticks(3);
    cmp("t4_both_frozen", 8'(bus.disp_m), 8'd5);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    step_cyc();
    cmp("t4_release", 8'(bus.disp_m), 8'd5);
    press_mode();
    cmp("t4_timerM", 8'(bus.timerM), 8'd5);
    cmp("t4_timerH", 8'(bus.timerH), 8'd23);

    // async reset mid-EDIT_M with shadow minute 7
    press_mode();
    press_mode();
    press_up(2);
    cmp("t1_pre_m", 8'(bus.disp_m), 8'd7);
    rst = 1'b1;
    #1;
    cmp("t1_async_h",  8'(bus.timerH),  8'd0);
    cmp("t1_async_ed", 8'(bus.editing), 8'd0);
    step_cyc();
    rst = 1'b0;
    step_cyc();
    cmp("t1_timerH",  8'(bus.timerH),  8'd0);
    cmp("t1_timerM",  8'(bus.timerM),  8'd0);
    cmp("t1_enable",  8'(bus.enable),  8'd0);
    cmp("t1_editing", 8'(bus.editing), 8'd0);

    // edit timeout discards shadow
    press_mode();
    press_up(5);
    cmp("t5_shadow", 8'(bus.disp_h), 8'd5);
    ticks(P_TMO - 1);
    cmp("t5_not_yet", 8'(bus.editing), 8'd1);
    ticks(1);
    cmp("t5_abort",  8'(bus.editing), 8'd0);
    cmp("t5_timerH", 8'(bus.timerH),  8'd0);
    cmp("t5_disp_h", 8'(bus.disp_h),  8'd0);
    cmp("t5_blink",  8'(bus.blink),   8'd0);

    // step buttons ignored in IDLE
    press_up(2);
    press_down(1);
    cmp("idle_ign_h", 8'(bus.disp_h), 8'd0);

    // mode and up pressed together: mode wins, no step
    press_mode();
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    step_cyc();
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    step_cyc();
    cmp("mw_sel_m",  8'(bus.sel_h),  8'd0);
    cmp("mw_disp_m", 8'(bus.disp_m), 8'd0);
    press_mode();
    cmp("mw_timerH", 8'(bus.timerH), 8'd0);

    step_cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
